// File: rtl/sr_latch_driver.sv
// sr_latch_driver
// Turns one-word hold/set/reset commands into a timed c/s/r waveform for a
// gated SR latch (setup with c=0, enable pulse, hold with c=0), then checks
// the latch q/qbar feedback and reports a one-cycle done or err pulse.
// The forbidden s=r=1 combination is never driven, and s/r change only while
// c=0, so the latch only ever sees one clean request per enable pulse.
module sr_latch_driver #(
  parameter int SETUP_CYC = 1,  // cycles s/r settle with c=0 before the pulse (>=1)
  parameter int PULSE_CYC = 2,  // cycles c is held high (>=1)
  parameter int HOLD_CYC  = 1   // cycles s/r stay put with c=0 after the pulse (>=1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       c,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Longest phase sets the width of the shared down-counter.
  localparam int MAX_SR_CYC = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_CYC    = (PULSE_CYC > MAX_SR_CYC) ? PULSE_CYC : MAX_SR_CYC;
  localparam int CNT_W      = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] LD_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_SET     = 2'b01,
    OP_RESET   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  // Registered state and outputs.
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  op_t              r_op;
  logic             r_c;
  logic             r_s;
  logic             r_r;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  // Next-state values from the combinational process.
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  op_t              w_op_nxt;
  logic             w_c_nxt;
  logic             w_s_nxt;
  logic             w_r_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;

  logic             w_accept;
  logic             w_phase_last;
  logic             w_fb_ok;
  op_t              w_cmd_op;

  assign w_cmd_op     = op_t'(cmd_op);
  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  assign w_phase_last = (r_cnt == LD_ONE);

  // Judge the latch feedback against what the stored command should produce.
  always_comb begin
    w_fb_ok = 1'b0;
    case (r_op)
      OP_SET:   w_fb_ok = q_fb && !qbar_fb;
      OP_RESET: w_fb_ok = !q_fb && qbar_fb;
      OP_HOLD:  w_fb_ok = (q_fb != qbar_fb);
      default:  w_fb_ok = 1'b0;
    endcase
  end

  // Sequence IDLE -> SETUP -> PULSE -> HOLD -> CHECK -> IDLE and derive next outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_s_nxt     = r_s;
    w_r_nxt     = r_r;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_cmd_op == OP_ILLEGAL) begin
            // Rejected in place: no latch activity, just the error pulse.
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_SETUP;
            w_cnt_nxt   = LD_SETUP;
            w_op_nxt    = w_cmd_op;
            w_s_nxt     = (w_cmd_op == OP_SET);
            w_r_nxt     = (w_cmd_op == OP_RESET);
          end
        end
      end

      ST_SETUP: begin
        if (w_phase_last) begin
          w_state_nxt = ST_PULSE;
          w_cnt_nxt   = LD_PULSE;
        end else begin
          w_cnt_nxt = r_cnt - LD_ONE;
        end
      end

      ST_PULSE: begin
        if (w_phase_last) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LD_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - LD_ONE;
        end
      end

      ST_HOLD: begin
        if (w_phase_last) begin
          w_state_nxt = ST_CHECK;
          w_cnt_nxt   = LD_ONE;
        end else begin
          w_cnt_nxt = r_cnt - LD_ONE;
        end
      end

      ST_CHECK: begin
        // Feedback is sampled at this exit edge; exactly one result pulses.
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_done_nxt  = w_fb_ok;
        w_err_nxt   = !w_fb_ok;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
      end
    endcase

    // Registered outputs follow the state being entered, so they line up
    // with the state register rather than lagging it by a cycle.
    w_c_nxt    = (w_state_nxt == ST_PULSE);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, phase counter and registered outputs; reset drops every output at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_HOLD;
      r_c     <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_c     <= w_c_nxt;
      r_s     <= w_s_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign c         = r_c;
  assign s         = r_s;
  assign r         = r_r;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // Safety properties of the latch interface.
  a_no_forbidden: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_s && r_r));
  a_c_only_in_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    r_c |-> (r_state == ST_PULSE));
  a_sr_stable_under_c: assert property (@(posedge clk) disable iff (!rst_n)
    (r_c && w_c_nxt) |-> ((w_s_nxt == r_s) && (w_r_nxt == r_r)));
  a_one_result: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_done && r_err));

endmodule
